writeback_unit: RTL and testbench

Drives the register file's single write port from two producers: the single-cycle ALU path and the long-latency load/store path. LSU results are buffered in a small FIFO and written when the ALU path leaves the port idle. A per-register pending scoreboard lets decode stall on registers whose long-latency result has not landed yet. The block sits between execute/memory and the register file write port.

---
 rtl/writeback_unit_pkg.sv | 15 +
 rtl/wb_fifo.sv | 53 +++++
 rtl/writeback_unit.sv | 110 +++++++++++
 tb/tb_writeback_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared widths and zero constants for the writeback path, plus the write-source tag.
package writeback_unit_pkg;

  localparam int unsigned DataBusBits = 32;
  localparam int unsigned RegAddrBits = 5;

  localparam logic [RegAddrBits-1:0] RegZero  = '0;
  localparam logic [DataBusBits-1:0] DataZero = '0;

  typedef enum logic {
    SrcAlu = 1'b0,
    SrcLsu = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with registered read/write pointers and an occupancy counter.
module wb_fifo
  import writeback_unit_pkg::*;
#(
  parameter int unsigned Width = 37,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port arbiter: ALU results win, buffered LSU results fill idle cycles,
// and a 32-bit pending scoreboard tracks outstanding long-latency destinations.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int unsigned DATA_W     = DataBusBits,
  parameter int unsigned REG_ADDR_W = RegAddrBits,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_rd_i,
  input  logic [DATA_W-1:0]     alu_data_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [REG_ADDR_W-1:0] lsu_rd_i,
  input  logic [DATA_W-1:0]     lsu_data_i,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  output logic [31:0]           pending_o,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0]     rf_wdata_o
);

  localparam int unsigned EntryW = REG_ADDR_W + DATA_W;
  localparam logic [REG_ADDR_W-1:0] RdZero = REG_ADDR_W'(RegZero);

  logic                  fifo_full, fifo_empty, fifo_pop, lsu_push;
  logic [EntryW-1:0]     fifo_rdata;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0]     head_data;

  logic                  rf_we_d, rf_we_q;
  logic [REG_ADDR_W-1:0] rf_waddr_d, rf_waddr_q;
  logic [DATA_W-1:0]     rf_wdata_d, rf_wdata_q;
  wb_src_e               src_d, src_q;
  logic [31:0]           pending_d, pending_q, set_mask, clr_mask;

  assign lsu_ready_o = ~reset & ~fifo_full;
  assign lsu_push    = lsu_valid_i & lsu_ready_o;
  assign {head_rd, head_data} = fifo_rdata;

  wb_fifo #(
    .Width(EntryW),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (lsu_push),
    .wdata_i({lsu_rd_i, lsu_data_i}),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Writes to register 0 are consumed (FIFO still pops) but never raise the enable.
  always_comb begin
    fifo_pop   = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    src_d      = SrcAlu;
    if (alu_valid_i) begin
      rf_we_d    = (alu_rd_i != RdZero);
      rf_waddr_d = alu_rd_i;
      rf_wdata_d = alu_data_i;
    end else if (!fifo_empty) begin
      fifo_pop   = 1'b1;
      rf_we_d    = (head_rd != RdZero);
      rf_waddr_d = head_rd;
      rf_wdata_d = head_data;
      src_d      = SrcLsu;
    end
  end

  // Set is OR-ed in after the clear so a same-edge re-issue keeps the bit.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid_i) set_mask = 32'd1 << issue_rd_i;
    if (rf_we_q && (src_q == SrcLsu)) clr_mask = 32'd1 << rf_waddr_q;
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= RdZero;
      rf_wdata_q <= DATA_W'(DataZero);
      src_q      <= SrcAlu;
      pending_q  <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      src_q      <= src_d;
      pending_q  <= pending_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign pending_o  = pending_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit: one task per scenario.
module tb_writeback_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, lsu_valid, lsu_ready, issue_valid;
  logic [AW-1:0] alu_rd, lsu_rd, issue_rd, rf_waddr;
  logic [DW-1:0] alu_data, lsu_data, rf_wdata;
  logic [31:0]   pending;
  logic          rf_we;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  writeback_unit #(
    .DATA_W    (DW),
    .REG_ADDR_W(AW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid_i  (alu_valid),
    .alu_rd_i     (alu_rd),
    .alu_data_i   (alu_data),
    .lsu_valid_i  (lsu_valid),
    .lsu_ready_o  (lsu_ready),
    .lsu_rd_i     (lsu_rd),
    .lsu_data_i   (lsu_data),
    .issue_valid_i(issue_valid),
    .issue_rd_i   (issue_rd),
    .pending_o    (pending),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hFFFF;
    lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'hEEEE;
    issue_valid = 1'b1; issue_rd = 5'd7;
    for (int c = 0; c < 2; c++) begin
      next_cycle(); mid();
      n_cmp++; if (lsu_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", lsu_ready); end
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", rf_we); end
      n_cmp++; if (pending !== 32'h0) begin n_err++; $display("FAIL rst_pending: got %h want 0", pending); end
    end
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    mid();
    n_cmp++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", lsu_ready); end
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL post_rst_we: got %b want 0", rf_we); end
    n_cmp++; if (rf_waddr !== 5'd0) begin n_err++; $display("FAIL post_rst_waddr: got %h want 0", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'h0) begin n_err++; $display("FAIL post_rst_wdata: got %h want 0", rf_wdata); end
    n_cmp++; if (pending !== 32'h0) begin n_err++; $display("FAIL post_rst_pending: got %h want 0", pending); end
  endtask

  task automatic test_alu_write();
    next_cycle();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    next_cycle();
    alu_valid = 1'b0;
    mid();
    n_cmp++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL alu_we: got %b want 1", rf_we); end
    n_cmp++; if (rf_waddr !== 5'd5) begin n_err++; $display("FAIL alu_waddr: got %h want 5", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'h1234) begin n_err++; $display("FAIL alu_wdata: got %h want 1234", rf_wdata); end
    next_cycle(); mid();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL alu_we_drop: got %b want 0", rf_we); end
    n_cmp++; if (rf_wdata !== 32'h1234) begin n_err++; $display("FAIL alu_wdata_hold: got %h want 1234", rf_wdata); end
  endtask

  task automatic test_lsu_scoreboard();
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    next_cycle();
    issue_valid = 1'b0;
    mid();
    n_cmp++; if (pending !== 32'h80) begin n_err++; $display("FAIL sb_set: got %h want 80", pending); end
    next_cycle(); mid();
    n_cmp++; if (pending !== 32'h80) begin n_err++; $display("FAIL sb_hold: got %h want 80", pending); end
    next_cycle();
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hABCD;
    mid();
    n_cmp++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL sb_ready: got %b want 1", lsu_ready); end
    next_cycle();
    lsu_valid = 1'b0;
    mid();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL sb_we_early: got %b want 0", rf_we); end
    next_cycle(); mid();
    n_cmp++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL sb_we: got %b want 1", rf_we); end
    n_cmp++; if (rf_waddr !== 5'd7) begin n_err++; $display("FAIL sb_waddr: got %h want 7", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'hABCD) begin n_err++; $display("FAIL sb_wdata: got %h want abcd", rf_wdata); end
    n_cmp++; if (pending !== 32'h80) begin n_err++; $display("FAIL sb_still_pending: got %h want 80", pending); end
    next_cycle(); mid();
    n_cmp++; if (pending !== 32'h0) begin n_err++; $display("FAIL sb_clear: got %h want 0", pending); end
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL sb_we_drop: got %b want 0", rf_we); end
  endtask

  task automatic test_priority_backpressure();
    int nxt = 1;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      alu_valid = 1'b1; alu_rd = AW'(20 + k); alu_data = 32'h2000 + 32'(k);
      lsu_valid = 1'b1; lsu_rd = AW'(nxt); lsu_data = 32'h100 + 32'(nxt);
      mid();
      n_cmp++;
      if (lsu_ready !== (k < 4)) begin
        n_err++; $display("FAIL bp_ready[%0d]: got %b want %b", k, lsu_ready, (k < 4));
      end
      if (k > 0) begin
        n_cmp++;
        if (rf_we !== 1'b1 || rf_waddr !== AW'(19 + k)) begin
          n_err++; $display("FAIL bp_alu_win[%0d]: got we=%b addr=%0d want we=1 addr=%0d",
                            k, rf_we, rf_waddr, 19 + k);
        end
      end
      if (lsu_ready) nxt++;
    end
    next_cycle();
    alu_valid = 1'b0;
    lsu_rd = AW'(nxt); lsu_data = 32'h100 + 32'(nxt);
    mid();
    n_cmp++; if (lsu_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_no_pass: got %b want 0", lsu_ready); end
    n_cmp++; if (rf_waddr !== 5'd25) begin n_err++; $display("FAIL bp_last_alu: got %0d want 25", rf_waddr); end
    for (int j = 1; j <= 5; j++) begin
      next_cycle();
      if (j == 2) lsu_valid = 1'b0;
      mid();
      if (j == 1) begin
        n_cmp++; if (lsu_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_again: got %b want 1", lsu_ready); end
      end
      n_cmp++;
      if (rf_we !== 1'b1 || rf_waddr !== AW'(j) || rf_wdata !== 32'h100 + 32'(j)) begin
        n_err++; $display("FAIL bp_drain[%0d]: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                          j, rf_we, rf_waddr, rf_wdata, j, 32'h100 + 32'(j));
      end
    end
    next_cycle(); mid();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b want 0", rf_we); end
  endtask

  task automatic test_reg_zero();
    next_cycle();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h66;
    issue_valid = 1'b1; issue_rd = 5'd0;
    next_cycle();
    idle_inputs();
    mid();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL r0_alu_we: got %b want 0", rf_we); end
    n_cmp++; if (pending !== 32'h0) begin n_err++; $display("FAIL r0_pending: got %h want 0", pending); end
    next_cycle();
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
    mid();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL r0_lsu_we: got %b want 0", rf_we); end
    next_cycle();
    lsu_valid = 1'b0;
    mid();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL r0_gap_we: got %b want 0", rf_we); end
    next_cycle(); mid();
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h33) begin
      n_err++; $display("FAIL r0_drained: got we=%b addr=%0d data=%h want we=1 addr=3 data=33",
                        rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_set_clear();
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    next_cycle();
    issue_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    mid();
    n_cmp++; if (pending !== 32'h200) begin n_err++; $display("FAIL sc_set: got %h want 200", pending); end
    next_cycle();
    lsu_valid = 1'b0;
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    mid();
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin
      n_err++; $display("FAIL sc_retire: got we=%b addr=%0d want we=1 addr=9", rf_we, rf_waddr);
    end
    next_cycle();
    issue_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h98;
    mid();
    n_cmp++; if (pending !== 32'h200) begin n_err++; $display("FAIL sc_set_wins: got %h want 200", pending); end
    next_cycle();
    lsu_valid = 1'b0;
    next_cycle(); mid();
    n_cmp++; if (rf_wdata !== 32'h98) begin n_err++; $display("FAIL sc_second_data: got %h want 98", rf_wdata); end
    next_cycle(); mid();
    n_cmp++; if (pending !== 32'h0) begin n_err++; $display("FAIL sc_final_clear: got %h want 0", pending); end
  endtask

  task automatic test_mid_reset();
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd12;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hCC;
    next_cycle();
    issue_valid = 1'b0; lsu_valid = 1'b0;
    mid();
    n_cmp++; if (pending !== 32'h1000) begin n_err++; $display("FAIL mr_pending: got %h want 1000", pending); end
    next_cycle();
    reset = 1'b1; alu_valid = 1'b0;
    mid();
    n_cmp++; if (lsu_ready !== 1'b0) begin n_err++; $display("FAIL mr_ready: got %b want 0", lsu_ready); end
    next_cycle();
    reset = 1'b0;
    mid();
    n_cmp++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0 || pending !== 32'h0) begin
      n_err++; $display("FAIL mr_outputs: got we=%b addr=%0d data=%h pend=%h want all zero",
                        rf_we, rf_waddr, rf_wdata, pending);
    end
    for (int c = 0; c < 2; c++) begin
      next_cycle(); mid();
      n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL mr_fifo_flushed[%0d]: got %b want 0", c, rf_we); end
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_alu_write();
    test_lsu_scoreboard();
    test_priority_backpressure();
    test_reg_zero();
    test_set_clear();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

endmodule
